// File: rtl/lsu_mem_stage.sv
// Memory-access stage: drives the ready/valid data-memory port for loads and stores,
// stalls upstream while a transaction is outstanding, and returns extended load data.
module lsu_mem_stage #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  ByteAccess,
   input  logic [2:0]  ByteSrc,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic [4:0]  Rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic [4:0]  ld_rd,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RDATA} state_t;

   state_t      state;
   logic [7:0]  waitCnt;
   logic        reqWe;
   logic [3:0]  reqBe;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic [2:0]  reqSrc;
   logic [1:0]  reqOff;
   logic [4:0]  reqRd;

   logic        isAccess;
   logic        isStore;
   logic        misAligned;
   logic        reqNow;
   logic [3:0]  beNow;
   logic [31:0] wdataNow;

   // Select the byte or halfword lane named by the latched offset and extend it.
   function automatic logic [31:0] extractLoad(input logic [31:0] d, input logic [2:0] src,
                                              input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = d[{off[1], 4'b0000} +: 16];
      case (src)
         3'b000:  return {24'd0, b};
         3'b001:  return {16'd0, h};
         3'b010:  return {{24{b[7]}}, b};
         3'b011:  return {{16{h[15]}}, h};
         default: return d;
      endcase
   endfunction

   // Decode the incoming access: size-dependent byte enables, replicated data, alignment.
   always_comb begin
      isAccess   = valid_i & (MemRead | MemWrite);
      isStore    = MemWrite;
      beNow      = 4'b1111;
      wdataNow   = WriteData;
      misAligned = (Addr[1:0] != 2'b00);
      case (ByteAccess)
         2'b01: begin
            beNow      = 4'b0001 << Addr[1:0];
            wdataNow   = {4{WriteData[7:0]}};
            misAligned = 1'b0;
         end
         2'b10: begin
            beNow      = 4'b0011 << {Addr[1], 1'b0};
            wdataNow   = {2{WriteData[15:0]}};
            misAligned = Addr[0];
         end
         default: ;
      endcase
      reqNow = (state == IDLE) & isAccess & ~misAligned;
   end

   // Port and stall outputs: live inputs while IDLE, latched fields while waiting for grant.
   always_comb begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_be    = 4'b0000;
      dmem_addr  = 32'd0;
      dmem_wdata = 32'd0;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (reqNow) begin
               dmem_req   = 1'b1;
               dmem_we    = isStore;
               dmem_be    = beNow;
               dmem_addr  = {Addr[31:2], 2'b00};
               dmem_wdata = wdataNow;
               stall      = ~(dmem_gnt & isStore);
            end
         end
         WAIT_GNT: begin
            dmem_req   = 1'b1;
            dmem_we    = reqWe;
            dmem_be    = reqBe;
            dmem_addr  = reqAddr;
            dmem_wdata = reqWdata;
            stall      = ~(dmem_gnt & reqWe);
         end
         WAIT_RDATA: stall = ~dmem_rvalid;
         default: ;
      endcase
   end

   // Transaction sequencing, request latching, timeout counting and registered result pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         waitCnt  <= 8'd0;
         reqWe    <= 1'b0;
         reqBe    <= 4'd0;
         reqAddr  <= 32'd0;
         reqWdata <= 32'd0;
         reqSrc   <= 3'd0;
         reqOff   <= 2'd0;
         reqRd    <= 5'd0;
         ld_valid <= 1'b0;
         ld_data  <= 32'd0;
         ld_rd    <= 5'd0;
         misalign <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         ld_valid <= 1'b0;
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (isAccess && misAligned) begin
                  misalign <= 1'b1;
               end else if (reqNow) begin
                  reqWe    <= isStore;
                  reqBe    <= beNow;
                  reqAddr  <= {Addr[31:2], 2'b00};
                  reqWdata <= wdataNow;
                  reqSrc   <= ByteSrc;
                  reqOff   <= Addr[1:0];
                  reqRd    <= Rd;
                  waitCnt  <= 8'd0;
                  if (!dmem_gnt) begin
                     state <= WAIT_GNT;
                  end else if (!isStore) begin
                     state <= WAIT_RDATA;
                  end
               end
            end
            WAIT_GNT: begin
               waitCnt <= 8'd0;
               if (dmem_gnt) begin
                  state <= reqWe ? IDLE : WAIT_RDATA;
               end
            end
            WAIT_RDATA: begin
               if (dmem_rvalid) begin
                  ld_valid <= 1'b1;
                  ld_data  <= extractLoad(dmem_rdata, reqSrc, reqOff);
                  ld_rd    <= reqRd;
                  state    <= IDLE;
               end else if (waitCnt == 8'(MAX_WAIT - 1)) begin
                  bus_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a transaction-level model
// of byte-enable, lane-replication, alignment and load-extension rules.
module tb_lsu_mem_stage;

   localparam int MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_i = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [1:0]  ByteAccess = 2'd0;
   logic [2:0]  ByteSrc = 3'd0;
   logic [31:0] Addr = 32'd0;
   logic [31:0] WriteData = 32'd0;
   logic [4:0]  Rd = 5'd0;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        dmem_req;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        stall;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic [4:0]  ld_rd;
   logic        misalign;
   logic        bus_err;

   int          total = 0;
   int          bad = 0;
   logic [31:0] expLd = 32'd0;
   logic [4:0]  expRd = 5'd0;

   lsu_mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .MemRead(MemRead), .MemWrite(MemWrite),
      .ByteAccess(ByteAccess), .ByteSrc(ByteSrc), .Addr(Addr), .WriteData(WriteData), .Rd(Rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_rd(ld_rd), .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: load result computed by shifting and masking the returned word.
   function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [2:0] src,
                                             input logic [31:0] addr);
      logic [31:0] mask;
      logic [31:0] val;
      int          sh;
      bit          sgn;
      sh   = 0;
      mask = 32'hFFFF_FFFF;
      sgn  = (src == 3'b010) || (src == 3'b011);
      if (src == 3'b000 || src == 3'b010) begin
         sh   = 8 * int'(addr % 4);
         mask = 32'h0000_00FF;
      end else if (src == 3'b001 || src == 3'b011) begin
         sh   = 16 * int'((addr / 2) % 2);
         mask = 32'h0000_FFFF;
      end
      val = (rdata >> sh) & mask;
      if (sgn && ((val & ((mask >> 1) + 32'd1)) != 0)) val = val | ~mask;
      return val;
   endfunction

   task automatic checkIdle(input string tag);
      checkOutput({tag, "Req"}, 32'(dmem_req), 32'd0);
      checkOutput({tag, "Stall"}, 32'(stall), 32'd0);
   endtask

   // One full transaction; rvDelay=0 means the memory never answers.
   task automatic applyStimulus(input bit isStore, input bit both, input logic [1:0] size,
                                input logic [2:0] src, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [4:0] rd, input int gntDelay, input int rvDelay);
      logic [3:0]  eBe;
      logic [31:0] eWd;
      logic [31:0] eAddr;
      bit          mis;
      eAddr = addr & 32'hFFFF_FFFC;
      if (size == 2'd1) begin
         eBe = 4'(32'd1 << (addr % 4));
         eWd = {24'd0, wdata[7:0]} * 32'h0101_0101;
         mis = 1'b0;
      end else if (size == 2'd2) begin
         eBe = 4'(32'd3 << (addr & 32'd2));
         eWd = {16'd0, wdata[15:0]} * 32'h0001_0001;
         mis = (addr % 2) != 0;
      end else begin
         eBe = 4'hF;
         eWd = wdata;
         mis = (addr % 4) != 0;
      end
      @(posedge clk); #1;
      valid_i = 1'b1; MemRead = !isStore || both; MemWrite = isStore;
      ByteAccess = size; ByteSrc = src; Addr = addr; WriteData = wdata; Rd = rd;
      dmem_gnt = (gntDelay == 0); dmem_rvalid = 1'b0;
      #4;
      if (mis) begin
         checkIdle("mis");
         @(posedge clk); #1; valid_i = 1'b0; #4;
         checkOutput("misPulse", 32'(misalign), 32'd1);
         checkIdle("misAfter");
         @(posedge clk); #5;
         checkOutput("misClear", 32'(misalign), 32'd0);
         return;
      end
      for (int g = 0; g <= gntDelay; g++) begin
         if (g > 0) begin
            @(posedge clk); #1;
            valid_i = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
            Addr = $urandom; WriteData = $urandom; Rd = 5'($urandom);
            dmem_gnt = (g == gntDelay);
            #4;
         end
         checkOutput("req", 32'(dmem_req), 32'd1);
         checkOutput("we", 32'(dmem_we), 32'(isStore));
         checkOutput("be", 32'(dmem_be), 32'(eBe));
         checkOutput("addr", dmem_addr, eAddr);
         if (isStore) checkOutput("wdata", dmem_wdata, eWd);
         checkOutput("reqStall", 32'(stall), 32'(!(g == gntDelay && isStore)));
         checkOutput("noMis", 32'(misalign), 32'd0);
      end
      if (isStore) begin
         @(posedge clk); #1; valid_i = 1'b0; dmem_gnt = 1'b0; #4;
         checkIdle("stDone");
         return;
      end
      for (int r = 1; r <= MAX_WAIT; r++) begin
         @(posedge clk); #1;
         valid_i = 1'($urandom); MemRead = 1'b1; MemWrite = 1'($urandom); Addr = $urandom;
         dmem_gnt = 1'b0;
         dmem_rvalid = (r == rvDelay);
         dmem_rdata = (r == rvDelay) ? rdata : $urandom;
         #4;
         checkOutput("waitReq", 32'(dmem_req), 32'd0);
         checkOutput("waitStall", 32'(stall), 32'(r != rvDelay));
         checkOutput("waitLdv", 32'(ld_valid), 32'd0);
         checkOutput("waitErr", 32'(bus_err), 32'd0);
         if (r == rvDelay) break;
      end
      @(posedge clk); #1;
      valid_i = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      #4;
      if (rvDelay >= 1 && rvDelay <= MAX_WAIT) begin
         expLd = modelLoad(rdata, src, addr);
         expRd = rd;
         checkOutput("ldValid", 32'(ld_valid), 32'd1);
         checkOutput("busErrNo", 32'(bus_err), 32'd0);
      end else begin
         checkOutput("busErr", 32'(bus_err), 32'd1);
         checkOutput("ldvNoErr", 32'(ld_valid), 32'd0);
      end
      checkOutput("ldData", ld_data, expLd);
      checkOutput("ldRd", 32'(ld_rd), 32'(expRd));
      checkIdle("ldDone");
      @(posedge clk); #5;
      checkOutput("ldvClear", 32'(ld_valid), 32'd0);
      checkOutput("errClear", 32'(bus_err), 32'd0);
      checkOutput("ldHold", ld_data, expLd);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [2:0]  src;
      bit          st;
      int          rv;
      #12;
      checkIdle("rst");
      checkOutput("rstBe", 32'(dmem_be), 32'd0);
      checkOutput("rstLdv", 32'(ld_valid), 32'd0);
      checkOutput("rstLdData", ld_data, 32'd0);
      checkOutput("rstLdRd", 32'(ld_rd), 32'd0);
      checkOutput("rstErr", 32'(bus_err | misalign), 32'd0);
      reset = 1'b0;

      applyStimulus(1, 0, 2'b01, 3'b000, 32'h103, 32'hA5, 32'd0, 5'd1, 0, 0);
      applyStimulus(0, 0, 2'b01, 3'b010, 32'h202, 32'd0, 32'h12F0_3456, 5'd2, 0, 1);
      applyStimulus(0, 0, 2'b01, 3'b000, 32'h202, 32'd0, 32'h12F0_3456, 5'd3, 0, 1);
      applyStimulus(0, 0, 2'b10, 3'b011, 32'h302, 32'd0, 32'h8001_7FFF, 5'd4, 3, 2);
      applyStimulus(0, 0, 2'b00, 3'b100, 32'h401, 32'd0, 32'd0, 5'd5, 0, 1);
      applyStimulus(1, 0, 2'b10, 3'b001, 32'h403, 32'h1234, 32'd0, 5'd6, 0, 0);
      applyStimulus(0, 0, 2'b00, 3'b100, 32'h404, 32'd0, 32'hDEAD_BEEF, 5'd7, 1, MAX_WAIT);
      applyStimulus(0, 0, 2'b00, 3'b100, 32'h408, 32'd0, 32'h1111_2222, 5'd8, 0, 0);

      // A late answer after a timeout must not produce a load result.
      @(posedge clk); #1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF; #4;
      checkOutput("lateStall", 32'(stall), 32'd0);
      @(posedge clk); #1; dmem_rvalid = 1'b0; #4;
      checkOutput("lateLdv", 32'(ld_valid), 32'd0);
      checkOutput("lateLdData", ld_data, expLd);

      // Asynchronous reset in the middle of waiting for read data.
      @(posedge clk); #1;
      valid_i = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ByteAccess = 2'b00; ByteSrc = 3'b100;
      Addr = 32'h500; Rd = 5'd9; dmem_gnt = 1'b1;
      @(posedge clk); #1; valid_i = 1'b0; dmem_gnt = 1'b0; #4;
      checkOutput("preRstStall", 32'(stall), 32'd1);
      @(posedge clk); #2; reset = 1'b1; #1;
      checkIdle("midRst");
      checkOutput("midRstLdData", ld_data, 32'd0);
      checkOutput("midRstLdRd", 32'(ld_rd), 32'd0);
      checkOutput("midRstFlags", 32'(ld_valid | bus_err | misalign), 32'd0);
      expLd = 32'd0; expRd = 5'd0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA; #4;
      @(posedge clk); #1; dmem_rvalid = 1'b0; #4;
      checkOutput("postRstLdv", 32'(ld_valid), 32'd0);
      checkOutput("postRstLdData", ld_data, 32'd0);
      applyStimulus(0, 0, 2'b00, 3'b100, 32'h500, 32'd0, 32'hCAFE_F00D, 5'd10, 0, 1);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            @(posedge clk); #1;
            valid_i = 1'($urandom); MemRead = 1'b0; MemWrite = 1'b0;
            if (!valid_i) begin MemRead = 1'($urandom); MemWrite = 1'($urandom); end
            Addr = $urandom; #4;
            checkIdle("noAccess");
            @(posedge clk); #1; valid_i = 1'b0; #4;
            checkOutput("noAccessMis", 32'(misalign), 32'd0);
         end
         st = 1'($urandom);
         sz = 2'($urandom_range(0, 2));
         if (sz == 2'd1)      src = $urandom_range(0, 1) ? 3'b010 : 3'b000;
         else if (sz == 2'd2) src = $urandom_range(0, 1) ? 3'b011 : 3'b001;
         else                 src = 3'($urandom_range(4, 7));
         rv = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
         if ($urandom_range(0, 7) == 0) rv = MAX_WAIT;
         applyStimulus(st, 1'($urandom), sz, src, $urandom, $urandom, $urandom,
                       5'($urandom), $urandom_range(0, 3), rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage of the 6-stage pipeline. Consumes the decoder's ByteAccess/ByteSrc for loads and stores and drives a ready/valid data-memory port.
- Store path: generates byte enables and lane-replicated write data.
- Load path: extracts and sign/zero-extends the load result into a registered writeback value.
- Stalls upstream while a memory transaction is outstanding. Flags misaligned accesses and response timeouts.

Parameters:
- MAX_WAIT, 15, cycles allowed from grant to dmem_rvalid before bus_err (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_i  in  1  stage holds a valid instruction
- MemRead  in  1  load
- MemWrite  in  1  store
- ByteAccess  in  2  00 word, 01 byte, 10 half
- ByteSrc  in  3  load format: 000 lbu, 001 lhu, 010 lb, 011 lh, 100 lw; 101-111 treated as 100
- Addr  in  32  effective address from ALU
- WriteData  in  32  store data (rs2)
- Rd  in  5  destination register
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_be  out  4  byte enables
- dmem_addr  out  32  {Addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- stall  out  1  hold upstream stages
- ld_valid  out  1  one-cycle pulse, load result valid
- ld_data  out  32  extended load result (registered)
- ld_rd  out  5  destination of ld_data (registered)
- misalign  out  1  one-cycle pulse, misaligned access rejected
- bus_err  out  1  one-cycle pulse, rvalid timeout

Behaviour:
- Reset is asynchronous and active-high, using one clock. On reset:
  - State goes to IDLE and the wait counter goes to 0.
  - dmem_req, dmem_we, dmem_be, stall, ld_valid, ld_data, ld_rd, misalign and bus_err are all 0.
  - Reset mid-transaction abandons the transaction. A late dmem_rvalid arriving in IDLE is ignored.
- An access is when valid_i & (MemRead | MemWrite). MemRead and MemWrite both high is treated as a store.
- Alignment:
  - Half is misaligned if Addr[0]=1.
  - Word is misaligned if Addr[1:0]!=0.
  - A misaligned access issues no request and does not stall. misalign pulses on the next clock.
- Byte enables:
  - byte: 4'b0001<<Addr[1:0]
  - half: 4'b0011<<{Addr[1],1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{WriteData[7:0]}}
  - half: {2{WriteData[15:0]}}
  - word: WriteData
- FSM states: IDLE, WAIT_GNT, WAIT_RDATA.
  - IDLE with an aligned access: dmem_req=1 combinationally from the inputs. The request fields (addr, be, wdata, we, ByteSrc, Addr[1:0], Rd) are latched every cycle an access is accepted.
    - gnt=1 and store: complete, stay IDLE, stall=0.
    - gnt=1 and load: go to WAIT_RDATA, stall=1.
    - gnt=0: go to WAIT_GNT, stall=1.
  - WAIT_GNT: dmem_req=1 with the latched fields held stable; stall=1.
    - On gnt, a store goes to IDLE (stall=0 that cycle).
    - On gnt, a load goes to WAIT_RDATA.
  - WAIT_RDATA: dmem_req=0. The counter increments each cycle, and stall=1 except in the rvalid cycle.
    - On dmem_rvalid: capture the extended data into ld_data and the latched Rd into ld_rd. ld_valid pulses the next cycle. Go to IDLE.
    - If the counter reaches MAX_WAIT without rvalid: bus_err pulses, ld_valid stays 0, go to IDLE.
    - The counter clears on entering WAIT_RDATA.
- Load extraction uses the latched Addr[1:0]:
  - byte: rdata[8*Addr[1:0]+:8]
  - half: rdata[16*Addr[1]+:16]
  - Sign- or zero-extend to 32 bits per the latched ByteSrc.
- Minimum load latency is 2 cycles: request+gnt at cycle 0, rvalid at cycle 1, ld_valid at cycle 2. rvalid in the gnt cycle is not allowed.
- Inputs are ignored whenever state != IDLE, because upstream is stalled. ld_data holds its value between loads.

Test Plan:
1. sb: Addr=0x103, WriteData=0xA5, gnt same cycle -> dmem_be=1000, dmem_addr=0x100, dmem_wdata=0xA5A5A5A5, dmem_we=1, stall=0.
2. lb: Addr=0x202, ByteSrc=010, gnt cycle 0, rvalid cycle 1 with rdata=0x12F03456 -> ld_data=0xFFFFFFF0, ld_valid at cycle 2, stall high at cycle 0 only. Repeat with lbu (ByteSrc=000) -> 0x000000F0.
3. lh: Addr=0x302, rdata=0x8001_7FFF, gnt delayed 3 cycles -> dmem_req held 4 cycles with fields stable, ld_data=0xFFFF8001, stall until the rvalid cycle.
4. lw at Addr=0x401 and sh at 0x403 -> misalign pulse on each, no dmem_req, stall=0.
5. lw granted, no rvalid for MAX_WAIT=15 cycles -> bus_err pulse, ld_valid=0, IDLE. A late rvalid afterwards produces no ld_valid.
6. Reset asserted asynchronously mid WAIT_RDATA -> all outputs 0 immediately. A subsequent rvalid is ignored, and the next lw completes normally.
